// File: rtl/bcd_display_pkg.sv
// Shared types, segment constants and glyph table
// for the multiplexed 7-segment scanner.
package bcd_display_pkg;

  typedef logic [3:0] bcd_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  // {g,f,e,d,c,b,a}, active-low; A..F show a dash
  localparam logic [6:0] GLYPH [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, SEG_DASH, SEG_DASH,
    SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH
  };

endpackage

// File: rtl/bcd_display_scanner_if.sv
// Display-side bundle: capture inputs from the
// counter chain and the multiplexed pin outputs.
interface bcd_display_scanner_if #(
  parameter int N_DIGITS = 4
);

  logic                    load;
  logic [4*N_DIGITS-1:0]   digits;
  logic [N_DIGITS-1:0]     dp_in;
  logic                    blank;
  logic [N_DIGITS-1:0]     an;
  logic [6:0]              seg;
  logic                    dp;
  logic                    frame_done;

  modport master (
    output load, digits, dp_in, blank,
    input  an, seg, dp, frame_done
  );

  modport slave (
    input  load, digits, dp_in, blank,
    output an, seg, dp, frame_done
  );

endinterface

// File: rtl/bcd_to_7seg.sv
// Combinational BCD to active-low 7-segment
// decoder; codes above 9 give a dash.
module bcd_to_7seg
  import bcd_display_pkg::*;
(
  input  bcd_t       bcd,
  output logic [6:0] seg
);

  assign seg = GLYPH[bcd];

endmodule

// File: rtl/bcd_display_scanner.sv
// Captures packed BCD digits on a load edge and
// scans them onto one 7-segment bus.
module bcd_display_scanner
  import bcd_display_pkg::*;
#(
  parameter int N_DIGITS    = 4,
  parameter int REFRESH_DIV = 100000,
  parameter bit BLANK_LZ    = 1'b1
) (
  input logic                  clk,
  input logic                  rst,
  bcd_display_scanner_if.slave bus
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW =
    (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_MAX =
    CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX =
    IW'(N_DIGITS - 1);

  logic                     load_q;
  logic [N_DIGITS-1:0][3:0] sh_dig;
  logic [N_DIGITS-1:0]      sh_dp;
  logic [CW-1:0]            cnt;
  logic [IW-1:0]            idx;

  logic                     cap;
  logic                     slot_end;
  logic                     last_idx;
  logic                     lit;
  logic                     zero_run;
  logic [N_DIGITS-1:0]      lz_blank;
  logic [N_DIGITS-1:0]      an_sel;
  bcd_t                     cur_bcd;
  logic [6:0]               cur_seg;

  assign cap      = bus.load & ~load_q;
  assign slot_end = (cnt == CNT_MAX);
  assign last_idx = (idx == IDX_MAX);
  assign cur_bcd  = sh_dig[idx];
  assign an_sel   = ~(N_DIGITS'(1) << idx);
  assign lit      = (cnt != '0) & ~lz_blank[idx];

  // A digit is a leading zero when it and all
  // higher digits are zero; digit 0 always shows.
  always_comb begin
    lz_blank = '0;
    zero_run = 1'b1;
    for (int i = N_DIGITS - 1; i > 0; i--) begin
      zero_run    = zero_run & (sh_dig[i] == 4'd0);
      lz_blank[i] = BLANK_LZ & zero_run;
    end
  end

  bcd_to_7seg u_dec (
    .bcd (cur_bcd),
    .seg (cur_seg)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_q         <= 1'b0;
      sh_dig         <= '0;
      sh_dp          <= '0;
      cnt            <= '0;
      idx            <= '0;
      bus.an         <= '1;
      bus.seg        <= SEG_BLANK;
      bus.dp         <= 1'b1;
      bus.frame_done <= 1'b0;
    end else begin
      load_q <= bus.load;
      if (cap) begin
        sh_dig <= bus.digits;
        sh_dp  <= bus.dp_in;
      end
      cnt <= slot_end ? '0 : cnt + CW'(1);
      if (slot_end)
        idx <= last_idx ? '0 : idx + IW'(1);
      bus.frame_done <= slot_end & last_idx;
      if (lit) begin
        bus.an  <= bus.blank ? '1 : an_sel;
        bus.seg <= cur_seg;
        bus.dp  <= ~sh_dp[idx];
      end else begin
        bus.an  <= '1;
        bus.seg <= SEG_BLANK;
        bus.dp  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Randomized and directed bench for the scanner
// against a cycle-position reference model.
module tb_bcd_display_scanner;

  localparam int N = 4;
  localparam int R = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  bcd_display_scanner_if #(.N_DIGITS(N)) bus ();

  bcd_display_scanner #(
    .N_DIGITS    (N),
    .REFRESH_DIV (R),
    .BLANK_LZ    (1'b1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  logic [6:0] glyph [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h3F, 7'h3F,
    7'h3F, 7'h3F, 7'h3F, 7'h3F
  };

  int n_cmp = 0;
  int n_bad = 0;

  // reference state
  int          p;
  logic [15:0] m_dig;
  logic [3:0]  m_dp;
  logic        m_lq;

  // directed observation counters
  int n_fd, n_e, n_d, n_b, n_7, n_lit;
  int last_fd, gap_bad, t_run;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    p     = 0;
    m_dig = '0;
    m_dp  = '0;
    m_lq  = 1'b0;
  endtask

  task automatic tick();
    int c, i, d;
    logic lzb;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic e_dp, e_fd;
    c   = p % R;
    i   = (p / R) % N;
    d   = int'((m_dig >> (4 * i)) & 16'hF);
    lzb = (i > 0) && ((m_dig >> (4 * i)) == 16'd0);
    e_fd = (c == R - 1) && (i == N - 1);
    if (c == 0 || lzb) begin
      e_an  = 4'hF;
      e_seg = 7'h7F;
      e_dp  = 1'b1;
    end else begin
      e_an  = bus.blank ? 4'hF
                        : ~(4'(1) << i);
      e_seg = glyph[d];
      e_dp  = ~m_dp[i];
    end
    @(posedge clk);
    #1;
    chk("an", 32'(bus.an), 32'(e_an));
    chk("seg", 32'(bus.seg), 32'(e_seg));
    chk("dp", 32'(bus.dp), 32'(e_dp));
    chk("frame_done", 32'(bus.frame_done),
        32'(e_fd));
    if (bus.load && !m_lq) begin
      m_dig = bus.digits;
      m_dp  = bus.dp_in;
    end
    m_lq = bus.load;
    p++;
    t_run++;
    if (bus.frame_done) begin
      if (n_fd > 0 && t_run - last_fd != 16)
        gap_bad++;
      n_fd++;
      last_fd = t_run;
    end
    if (bus.an == 4'b1110) n_e++;
    if (bus.an == 4'b1101) n_d++;
    if (bus.an == 4'b1011) n_b++;
    if (bus.an == 4'b0111) n_7++;
    if (bus.an != 4'hF) n_lit++;
  endtask

  task automatic clr();
    n_fd = 0; n_e = 0; n_d = 0; n_b = 0;
    n_7 = 0; n_lit = 0; gap_bad = 0;
    last_fd = 0; t_run = 0;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic capture(input logic [15:0] v,
                         input logic [3:0] dpv);
    bus.digits = v;
    bus.dp_in  = dpv;
    bus.load   = 1'b1;
    tick();
    bus.load   = 1'b0;
    bus.digits = 16'($urandom);
    bus.dp_in  = 4'($urandom);
  endtask

  initial begin
    bus.load   = 1'b0;
    bus.digits = '0;
    bus.dp_in  = '0;
    bus.blank  = 1'b0;
    clr();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_an", 32'(bus.an), 32'hF);
    chk("rst_seg", 32'(bus.seg), 32'h7F);
    chk("rst_dp", 32'(bus.dp), 32'h1);
    chk("rst_fd", 32'(bus.frame_done), 32'h0);
    rst = 1'b0;
    model_reset();
    capture(16'h4321, 4'b0101);
    run(11);

    // asynchronous reset in the middle of a slot
    #3;
    rst = 1'b1;
    #1;
    chk("async_an", 32'(bus.an), 32'hF);
    chk("async_seg", 32'(bus.seg), 32'h7F);
    chk("async_dp", 32'(bus.dp), 32'h1);
    chk("async_fd", 32'(bus.frame_done), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    run(2);
    chk("first_slot", 32'(bus.an), 32'hE);
    run(14);

    // two digits, leading zeros blanked
    capture(16'h0018, 4'b0000);
    run(16);
    clr();
    run(16);
    chk("lz_slot0", 32'(n_e), 32'd3);
    chk("lz_slot1", 32'(n_d), 32'd3);
    chk("lz_slot2", 32'(n_b), 32'd0);
    chk("lz_slot3", 32'(n_7), 32'd0);

    // held load captures only on its rising edge
    bus.load = 1'b1;
    for (int k = 0; k < 10; k++) begin
      bus.digits = 16'($urandom);
      bus.dp_in  = 4'($urandom);
      tick();
    end
    bus.load = 1'b0;
    run(20);

    // invalid code shows a dash with its point
    capture(16'h00B0, 4'b0010);
    run(32);

    // frame_done cadence in free run
    capture(16'($urandom), 4'($urandom));
    clr();
    run(64);
    chk("fd_count", 32'(n_fd), 32'd4);
    chk("fd_gap", 32'(gap_bad), 32'd0);

    // all zero: only digit 0 lit, then blank
    capture(16'h0000, 4'b1110);
    run(16);
    clr();
    run(16);
    chk("zero_lit", 32'(n_lit), 32'd3);
    chk("zero_slot0", 32'(n_e), 32'd3);
    bus.blank = 1'b1;
    clr();
    run(32);
    chk("blank_lit", 32'(n_lit), 32'd0);
    chk("blank_fd", 32'(n_fd), 32'd2);
    chk("blank_gap", 32'(gap_bad), 32'd0);
    bus.blank = 1'b0;

    // random traffic with sparse high digits
    for (int k = 0; k < 400; k++) begin
      logic [15:0] v;
      v = 16'($urandom);
      v = v >> (4 * $urandom_range(0, 3));
      bus.digits = v;
      bus.dp_in  = 4'($urandom);
      bus.load   = ($urandom_range(0, 3) == 0);
      bus.blank  = ($urandom_range(0, 9) == 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
